demux_1_4_stream: RTL



---
 rtl/demux_1_4_stream.sv | 88 ++++++++
 1 files changed

// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demultiplexer: each accepted word lands in the
// one-entry output register of the channel picked by in_sel.
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

  chan_state_t      state_q [4];
  chan_state_t      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [WIDTH-1:0] data_d  [4];
  logic [3:0]       load;
  logic [3:0]       drain;
  logic             accept;

  // Only the selected channel gates the input, so a stalled channel
  // blocks the whole input (head-of-line) even if others are empty.
  always_comb begin
    in_ready = (state_q[in_sel] == EMPTY) | y_ready[in_sel];
    accept   = in_valid & in_ready;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      load[k]    = accept && (in_sel == 2'(k));
      drain[k]   = (state_q[k] == FULL) && y_ready[k];
      case (state_q[k])
        EMPTY: begin
          if (load[k]) begin
            state_d[k] = FULL;
            data_d[k]  = in_data;
          end
        end
        FULL: begin
          if (load[k]) begin
            data_d[k] = in_data;
          end else if (drain[k]) begin
            state_d[k] = EMPTY;
          end
        end
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  always_comb begin
    y_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      y_valid[k] = (state_q[k] == FULL);
    end
  end

  assign y0 = data_q[0];
  assign y1 = data_q[1];
  assign y2 = data_q[2];
  assign y3 = data_q[3];

endmodule
